// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: burst, response and FSM state definitions shared by the AXI SRAM slave
package axi_sram_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [2:0] {IDLE, W_BEAT, W_RESP, R_REQ, R_DATA} state_e;
endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI write/read channel bundle between a master and the SRAM slave
interface axi_sram_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W = 8
);
    logic [ID_W-1:0] AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [3:0] AWLEN;
    logic [2:0] AWSIZE;
    logic [1:0] AWBURST;
    logic AWVALID, AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic WLAST, WVALID, WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0] BRESP;
    logic BVALID, BREADY;
    logic [ID_W-1:0] ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0] ARLEN;
    logic [2:0] ARSIZE;
    logic [1:0] ARBURST;
    logic ARVALID, ARREADY;
    logic [ID_W-1:0] RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0] RRESP;
    logic RLAST, RVALID, RREADY;
    modport slave (
        input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address and per-beat legality check for one AXI burst
module axi_burst_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              err
);
    localparam int LB = $clog2(DATA_W / 8);
    localparam int SPAN_W = $clog2(DEPTH) + LB;
    logic [ADDR_W-1:0] step, wrap_mask;
    logic in_range, wrap_bad;
    always_comb begin
        step = ADDR_W'(1) << size;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        in_range = addr >= BASE_ADDR && ((addr - BASE_ADDR) >> SPAN_W) == '0;
        wrap_bad = !(len inside {4'd1, 4'd3, 4'd7, 4'd15}) || (addr & (step - ADDR_W'(1))) != '0;
        err = !in_range || size > 3'(LB) || burst == 2'b11 || (burst == WRAP && wrap_bad);
        next_addr = burst == FIXED ? addr :
                    burst == WRAP  ? (addr & ~wrap_mask) | ((addr + step) & wrap_mask) : addr + step;
    end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI slave in front of an internal byte-writable SRAM
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W = 8,
    parameter int DEPTH = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000
) (
    input logic ACLK,
    input logic ARESETn,
    axi_sram_slave_if.slave s
);
    localparam int LB = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    state_e state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
    logic [3:0] len_q, len_d, beat_q, beat_d;
    logic [2:0] size_q, size_d;
    logic [1:0] burst_q, burst_d, rresp_q, rresp_d;
    logic werr_q, werr_d, wr_pri_q, wr_pri_d, rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] widx;
    logic beat_err, aw_hs, ar_hs, w_hs, we, last_beat;

    axi_burst_addr_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .addr(addr_q), .size(size_q), .len(len_q), .burst(burst_q),
        .next_addr(next_addr), .err(beat_err)
    );

    // the losing channel sees READY low so a simultaneous request is never half-accepted
    assign s.AWREADY = ARESETn && state_q == IDLE && !(s.ARVALID && !wr_pri_q);
    assign s.ARREADY = ARESETn && state_q == IDLE && !(s.AWVALID && wr_pri_q);
    assign s.WREADY = state_q == W_BEAT;
    assign s.BVALID = state_q == W_RESP;
    assign s.BID = id_q;
    assign s.BRESP = werr_q ? SLVERR : OKAY;
    assign s.RVALID = state_q == R_DATA;
    assign s.RID = id_q;
    assign s.RDATA = rdata_q;
    assign s.RRESP = rresp_q;
    assign s.RLAST = state_q == R_DATA && rlast_q;
    assign aw_hs = s.AWVALID && s.AWREADY;
    assign ar_hs = s.ARVALID && s.ARREADY;
    assign w_hs = s.WVALID && s.WREADY;
    assign we = w_hs && !beat_err;
    assign last_beat = beat_q == len_q;
    assign widx = IDX_W'((addr_q - BASE_ADDR) >> LB);

    always_comb begin
        state_d = state_q;
        id_d = id_q;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        burst_d = burst_q;
        beat_d = beat_q;
        werr_d = werr_q;
        wr_pri_d = wr_pri_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        case (state_q)
            IDLE: if (aw_hs || ar_hs) begin
                id_d = aw_hs ? s.AWID : s.ARID;
                addr_d = aw_hs ? s.AWADDR : s.ARADDR;
                len_d = aw_hs ? s.AWLEN : s.ARLEN;
                size_d = aw_hs ? s.AWSIZE : s.ARSIZE;
                burst_d = aw_hs ? s.AWBURST : s.ARBURST;
                beat_d = '0;
                werr_d = 1'b0;
                wr_pri_d = !aw_hs;
                state_d = aw_hs ? W_BEAT : R_REQ;
            end
            W_BEAT: if (w_hs) begin
                werr_d = werr_q || beat_err || (s.WLAST != last_beat);
                addr_d = next_addr;
                beat_d = last_beat ? beat_q : beat_q + 4'd1;
                state_d = last_beat ? W_RESP : W_BEAT;
            end
            W_RESP: state_d = s.BREADY ? IDLE : W_RESP;
            R_REQ: begin
                rdata_d = beat_err ? '0 : mem[widx];
                rresp_d = beat_err ? SLVERR : OKAY;
                rlast_d = last_beat;
                state_d = R_DATA;
            end
            R_DATA: if (s.RREADY) begin
                addr_d = next_addr;
                beat_d = rlast_q ? beat_q : beat_q + 4'd1;
                state_d = rlast_q ? IDLE : R_REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            burst_q <= '0;
            beat_q <= '0;
            werr_q <= 1'b0;
            wr_pri_q <= 1'b1;
            rdata_q <= '0;
            rresp_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q <= id_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            burst_q <= burst_d;
            beat_q <= beat_d;
            werr_q <= werr_d;
            wr_pri_q <= wr_pri_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    always_ff @(posedge ACLK) begin
        for (int b = 0; b < NB; b++)
            if (we && s.WSTRB[b]) mem[widx][8*b +: 8] <= s.WDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI traffic against a word-level reference model of the SRAM slave
module tb_axi_sram_slave;
    import axi_sram_pkg::*;
    localparam int DATA_W = 32, ADDR_W = 32, ID_W = 8, DEPTH = 16384;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] TOP = BASE + DEPTH * 4;
    logic ACLK = 0;
    logic ARESETn;
    int tests = 0, fails = 0;
    logic [31:0] ref_mem [DEPTH];
    bit known [DEPTH];
    bit last_was_read = 1;
    time aw_t, ar_t;
    logic [31:0] wd [16];
    logic [3:0] ws [16];
    logic [31:0] rd_data [16];
    logic [1:0] rd_resp [16];
    logic rd_last [16];
    logic [1:0] b_resp;
    logic [7:0] b_id;

    axi_sram_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();
    axi_sram_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (.ACLK(ACLK), .ARESETn(ARESETn), .s(bus));

    always #5 ACLK = ~ACLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(logic [31:0] a, int size, int len, int burst, int i);
        logic [31:0] blk, lo;
        if (burst == 0) return a;
        if (burst == 2) begin
            blk = (len + 1) << size;
            lo = a / blk * blk;
            return lo + (a - lo + i * (1 << size)) % blk;
        end
        return a + i * (1 << size);
    endfunction

    function automatic bit beat_bad(logic [31:0] a, int size, int len, int burst);
        return size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15})) ||
               (burst == 2 && a % (1 << size) != 0) || a < BASE || a >= TOP;
    endfunction

    task automatic aw_send(logic [7:0] id, logic [31:0] a, int len, int size, int burst);
        int n = 0;
        @(negedge ACLK);
        bus.AWID = id; bus.AWADDR = a; bus.AWLEN = 4'(len); bus.AWSIZE = 3'(size);
        bus.AWBURST = 2'(burst); bus.AWVALID = 1;
        #1;
        while (!bus.AWREADY && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("aw_timeout", 1, 0);
        @(posedge ACLK);
        aw_t = $time; last_was_read = 0;
        #1 bus.AWVALID = 0;
    endtask

    task automatic ar_send(logic [7:0] id, logic [31:0] a, int len, int size, int burst);
        int n = 0;
        @(negedge ACLK);
        bus.ARID = id; bus.ARADDR = a; bus.ARLEN = 4'(len); bus.ARSIZE = 3'(size);
        bus.ARBURST = 2'(burst); bus.ARVALID = 1;
        #1;
        while (!bus.ARREADY && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("ar_timeout", 1, 0);
        @(posedge ACLK);
        ar_t = $time; last_was_read = 1;
        #1 bus.ARVALID = 0;
    endtask

    task automatic w_beat(logic [31:0] d, logic [3:0] st, logic last, int gap);
        int n = 0;
        repeat (gap) @(negedge ACLK);
        @(negedge ACLK);
        bus.WDATA = d; bus.WSTRB = st; bus.WLAST = last; bus.WVALID = 1;
        #1;
        while (!bus.WREADY && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("w_timeout", 1, 0);
        @(posedge ACLK);
        #1 bus.WVALID = 0;
    endtask

    task automatic b_take(int gap);
        int n = 0;
        repeat (gap) @(negedge ACLK);
        @(negedge ACLK);
        bus.BREADY = 1;
        #1;
        while (!bus.BVALID && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("b_timeout", 1, 0);
        b_resp = bus.BRESP; b_id = bus.BID;
        @(posedge ACLK);
        #1 bus.BREADY = 0;
    endtask

    task automatic r_beat(int stall, output logic [31:0] d, output logic [1:0] r, output logic l,
                          output logic [7:0] id);
        int n = 0;
        logic [35:0] held;
        @(negedge ACLK);
        #1;
        while (!bus.RVALID && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("r_timeout", 1, 0);
        held = {bus.RLAST, bus.RRESP, bus.RDATA, 1'b1};
        repeat (stall) begin
            @(negedge ACLK);
            #1 check("r_hold", {bus.RLAST, bus.RRESP, bus.RDATA, bus.RVALID}, held);
        end
        bus.RREADY = 1;
        d = bus.RDATA; r = bus.RRESP; l = bus.RLAST; id = bus.RID;
        @(posedge ACLK);
        #1 bus.RREADY = 0;
    endtask

    task automatic do_write(logic [31:0] a, int len, int size, int burst, bit bad_last);
        logic [7:0] id = 8'($urandom);
        bit err = bad_last;
        aw_send(id, a, len, size, burst);
        for (int i = 0; i <= len; i++) w_beat(wd[i], ws[i], (i == len) ^ bad_last, $urandom_range(0, 1));
        b_take($urandom_range(0, 2));
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba = beat_addr(a, size, len, burst, i);
            if (beat_bad(ba, size, len, burst)) err = 1;
            else begin
                int w = int'((ba - BASE) >> 2);
                for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
                if (bad_last) known[w] = 0;
                else if (ws[i] == 4'hF) known[w] = 1;
            end
        end
        check("bresp", b_resp, err ? SLVERR : OKAY);
        check("bid", b_id, id);
    endtask

    task automatic do_read(logic [31:0] a, int len, int size, int burst, int stall);
        logic [7:0] id = 8'($urandom);
        logic [7:0] rid;
        ar_send(id, a, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba = beat_addr(a, size, len, burst, i);
            bit bad = beat_bad(ba, size, len, burst);
            int w = int'((ba - BASE) >> 2);
            r_beat(stall < 0 ? $urandom_range(0, 2) : stall, rd_data[i], rd_resp[i], rd_last[i], rid);
            check("rresp", rd_resp[i], bad ? SLVERR : OKAY);
            check("rlast", rd_last[i], i == len);
            check("rid", rid, id);
            if (bad) check("rdata_err", rd_data[i], 0);
            else if (known[w]) check("rdata", rd_data[i], ref_mem[w]);
        end
    endtask

    initial begin
        logic [31:0] td;
        logic [1:0] tr;
        logic tl;
        logic [7:0] tid;
        bit exp_wr_first;
        int n;
        {bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWVALID} = '0;
        {bus.WDATA, bus.WSTRB, bus.WLAST, bus.WVALID, bus.BREADY} = '0;
        {bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARVALID, bus.RREADY} = '0;
        ARESETn = 1;
        #1 ARESETn = 0;
        #1;
        check("rst_ctrl", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST}, 0);
        check("rst_data", {bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA}, 0);
        repeat (3) @(negedge ACLK);
        ARESETn = 1;
        #1 check("ready_after_rst", {bus.AWREADY, bus.ARREADY}, 2'b11);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(BASE, 3, 2, INCR, 0);
        check("incr_wr_okay", b_resp, OKAY);
        do_read(BASE, 3, 2, INCR, -1);
        for (int i = 0; i < 4; i++) check("incr_rd", {rd_last[i], rd_data[i]}, {i == 3, 32'hA0 + i});

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(BASE + 4, 0, 2, INCR, 0);
        wd[0] = 32'h00EE0000; ws[0] = 4'b0100;
        do_write(BASE + 4, 0, 2, INCR, 0);
        do_read(BASE + 4, 0, 2, INCR, -1);
        check("strb_merge", rd_data[0], 32'h11EE3344);

        do_read(BASE + 8, 3, 2, WRAP, -1);
        check("wrap0", rd_data[0], 32'hA2);
        check("wrap1", rd_data[1], 32'hA3);
        check("wrap2", rd_data[2], 32'hA0);
        check("wrap3", rd_data[3], 32'h11EE3344);

        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(BASE + 32'h8000, 0, 2, INCR, 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h0000_8000, 0, 2, INCR, 0);
        check("oob_wr_slverr", b_resp, SLVERR);
        do_read(BASE + 32'h8000, 0, 2, INCR, -1);
        check("oob_no_alias", rd_data[0], 32'hCAFEF00D);
        do_read(BASE, 1, 3, INCR, -1);
        check("size3_rd", {rd_resp[0], rd_data[0], rd_resp[1], rd_data[1]}, {SLVERR, 32'h0, SLVERR, 32'h0});

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(TOP - 8, 3, 2, INCR, 0);
        check("top_wr_slverr", b_resp, SLVERR);
        do_read(TOP - 8, 3, 2, INCR, -1);
        check("top_rd_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, {OKAY, OKAY, SLVERR, SLVERR});

        wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(BASE + 32'h100, 1, 2, INCR, 1);
        check("wlast_err", b_resp, SLVERR);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            exp_wr_first = last_was_read;
            fork
                do_write(BASE + 32'h200, 3, 2, INCR, 0);
                do_read(BASE + 32'h300, 3, 2, INCR, 5);
            join
            check("rr_order", aw_t < ar_t, exp_wr_first);
            wd[0] = $urandom; ws[0] = 4'hF;
            do_write(BASE + 32'h400, 0, 2, INCR, 0);
        end

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        do_write(BASE + 32'h40, 3, 2, INCR, 0);
        ar_send(8'h5A, BASE + 32'h40, 3, 2, INCR);
        r_beat(0, td, tr, tl, tid);
        r_beat(0, td, tr, tl, tid);
        n = 0;
        @(negedge ACLK);
        #1;
        while (!bus.RVALID && n < 200) begin @(negedge ACLK); #1; n++; end
        if (n >= 200) check("r_timeout", 1, 0);
        ARESETn = 0;
        #1;
        check("midrst_ctrl", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST}, 0);
        check("midrst_data", {bus.BID, bus.BRESP, bus.RID, bus.RRESP, bus.RDATA}, 0);
        last_was_read = 1;
        @(negedge ACLK);
        ARESETn = 1;
        do_read(BASE + 32'h40, 3, 2, INCR, -1);
        check("post_rst_rd", rd_data[2], 32'hB2);

        for (int t = 0; t < 80; t++) begin
            int reg_sel = $urandom_range(0, 9);
            int bsel = $urandom_range(0, 9);
            int burst = bsel < 4 ? 1 : bsel < 7 ? 2 : bsel < 9 ? 0 : 3;
            int size = $urandom_range(0, 7) < 6 ? 2 : $urandom_range(0, 3);
            int len = (burst == 2 && $urandom_range(0, 5) != 0) ? (1 << $urandom_range(1, 4)) - 1
                                                                 : $urandom_range(0, 15);
            logic [31:0] a = reg_sel < 7 ? BASE + $urandom_range(0, 63) * 4 :
                             reg_sel < 9 ? TOP - $urandom_range(1, 8) * 4 : 32'h8000 + $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    ws[i] = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
                end
                do_write(a, len, size, burst, 0);
            end else do_read(a, len, size, burst, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
